// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg                                                          |
// | Shared constants, write-port record and index check for regfile_mp.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_pkg;

   localparam int RF_DATA_W_DEF = 32;
   localparam int RF_DEPTH_DEF  = 32;
   localparam int RF_IDX_W_DEF  = $clog2(RF_DEPTH_DEF);
   localparam int RF_IDX_W_MAX  = 6;

   // Wide enough for any supported depth; issue logic narrows as needed.
   typedef struct packed {
      logic                     en;
      logic [RF_IDX_W_MAX-1:0]  addr;
      logic [RF_DATA_W_DEF-1:0] data;
   } rf_wr_t;

   function automatic logic idx_valid(input int unsigned idx,
                                      input int unsigned depth,
                                      input logic        zero_reg);
      return (idx < depth) && !(zero_reg && (idx == 0));
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_scoreboard                                                        |
// | Per-register busy bits: writes clear, claims set, claim wins.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter  int DEPTH    = RF_DEPTH_DEF,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 1,
   parameter  int ZERO_REG = 1,
   localparam int IDX_W    = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_WR-1:0]             i_wen,
   input  logic [NUM_WR-1:0][IDX_W-1:0]  i_waddr,
   input  logic                          i_claim_en,
   input  logic [IDX_W-1:0]              i_claim_idx,
   input  logic [NUM_RD-1:0][IDX_W-1:0]  i_raddr,
   output logic [NUM_RD-1:0]             o_busy_rd,
   output logic [DEPTH-1:0]              o_busy_vec
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   always_comb begin
      w_busy_nxt = r_busy;
      for (int p = 0; p < NUM_WR; p++) begin
         if (i_wen[p] && idx_valid(32'(i_waddr[p]), DEPTH, ZERO_REG != 0))
            w_busy_nxt[i_waddr[p]] = 1'b0;
      end
      // A new producer supersedes the one retiring this cycle.
      if (i_claim_en && idx_valid(32'(i_claim_idx), DEPTH, ZERO_REG != 0))
         w_busy_nxt[i_claim_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_nxt;
   end

   always_comb begin
      o_busy_rd = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (idx_valid(32'(i_raddr[i]), DEPTH, ZERO_REG != 0))
            o_busy_rd[i] = r_busy[i_raddr[i]];
      end
   end

   assign o_busy_vec = r_busy;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_mp                                                           |
// | Multi-port register file with write bypass and busy scoreboard.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = RF_DATA_W_DEF,
   parameter  int DEPTH    = RF_DEPTH_DEF,
   parameter  int NUM_RD   = 2,
   parameter  int NUM_WR   = 1,
   parameter  int BYPASS   = 1,
   parameter  int ZERO_REG = 1,
   localparam int IDX_W    = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          RST,
   input  logic [NUM_WR-1:0]             wen,
   input  logic [NUM_WR-1:0][IDX_W-1:0]  waddr,
   input  logic [NUM_WR-1:0][DATA_W-1:0] wdata,
   input  logic [NUM_RD-1:0][IDX_W-1:0]  raddr,
   output logic [NUM_RD-1:0][DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]             rbusy,
   input  logic                          claim_en,
   input  logic [IDX_W-1:0]              claim_idx,
   output logic [DEPTH-1:0]              busy_vec
);

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [NUM_RD-1:0] w_hit;
   logic [NUM_RD-1:0] w_busy_rd;

   // Ascending port order makes the higher-numbered port win on a collision.
   always_ff @(posedge clk) begin
      if (RST) begin
         for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wen[p] && idx_valid(32'(waddr[p]), DEPTH, ZERO_REG != 0))
               r_regs[waddr[p]] <= wdata[p];
         end
      end
   end

   always_comb begin
      rdata = '0;
      w_hit = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (idx_valid(32'(raddr[i]), DEPTH, ZERO_REG != 0)) begin
            rdata[i] = r_regs[raddr[i]];
            if (BYPASS != 0) begin
               for (int p = 0; p < NUM_WR; p++) begin
                  if (wen[p] && (waddr[p] == raddr[i])) begin
                     rdata[i] = wdata[p];
                     w_hit[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (RST),
      .i_wen       (wen),
      .i_waddr     (waddr),
      .i_claim_en  (claim_en),
      .i_claim_idx (claim_idx),
      .i_raddr     (raddr),
      .o_busy_rd   (w_busy_rd),
      .o_busy_vec  (busy_vec)
   );

   // Forwarded data is the producer's result, so the register is no longer busy.
   assign rbusy = w_busy_rd & ~w_hit;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_mp                                                        |
// | Directed bench: one bypassing 4R/2W instance, one registered 2R/1W.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_regfile_mp;

   logic clk = 1'b0;
   logic RST = 1'b1;
   always #5 clk = ~clk;

   // Instance A: DEPTH=20, 4 read, 2 write, bypass, zero register.
   logic [1:0]           a_wen = '0;
   logic [1:0][4:0]      a_waddr = '0;
   logic [1:0][31:0]     a_wdata = '0;
   logic [3:0][4:0]      a_raddr = '0;
   logic [3:0][31:0]     a_rdata;
   logic [3:0]           a_rbusy;
   logic                 a_claim_en = 1'b0;
   logic [4:0]           a_claim_idx = '0;
   logic [19:0]          a_busy;

   // Instance B: defaults except no bypass.
   logic [0:0]           b_wen = '0;
   logic [0:0][4:0]      b_waddr = '0;
   logic [0:0][31:0]     b_wdata = '0;
   logic [1:0][4:0]      b_raddr = '0;
   logic [1:0][31:0]     b_rdata;
   logic [1:0]           b_rbusy;
   logic                 b_claim_en = 1'b0;
   logic [4:0]           b_claim_idx = '0;
   logic [31:0]          b_busy;

   int passed = 0;
   int total  = 0;

   regfile_mp #(.DATA_W(32), .DEPTH(20), .NUM_RD(4), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
      .clk(clk), .RST(RST), .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata),
      .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
      .claim_en(a_claim_en), .claim_idx(a_claim_idx), .busy_vec(a_busy)
   );

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
      .clk(clk), .RST(RST), .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
      .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
      .claim_en(b_claim_en), .claim_idx(b_claim_idx), .busy_vec(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Initial reset
      tick(); tick();
      RST = 1'b0;
      a_raddr = {5'd1, 5'd1, 5'd1, 5'd1};
      b_raddr = {5'd1, 5'd1};
      settle();
      chk("init_a_r1", a_rdata[0], 32'h0);
      chk("init_a_busy", 32'(a_busy), 32'h0);
      chk("init_b_busy", b_busy, 32'h0);

      // Preload r1 and claim r3, then reset for two cycles
      a_wen = 2'b01; a_waddr[0] = 5'd1; a_wdata[0] = 32'hAAAAAAAA;
      b_wen = 1'b1;  b_waddr[0] = 5'd1; b_wdata[0] = 32'hAAAAAAAA;
      a_claim_en = 1'b1; a_claim_idx = 5'd3;
      b_claim_en = 1'b1; b_claim_idx = 5'd3;
      tick();
      a_wen = '0; b_wen = '0; a_claim_en = 1'b0; b_claim_en = 1'b0;
      settle();
      chk("pre_a_r1", a_rdata[0], 32'hAAAAAAAA);
      chk("pre_b_r1", b_rdata[0], 32'hAAAAAAAA);
      chk("pre_a_busy", 32'(a_busy), 32'h8);
      chk("pre_b_busy", b_busy, 32'h8);
      RST = 1'b1;
      tick(); tick();
      RST = 1'b0;
      settle();
      chk("rst_a_rd0", a_rdata[0], 32'h0);
      chk("rst_a_rd3", a_rdata[3], 32'h0);
      chk("rst_b_rd1", b_rdata[1], 32'h0);
      chk("rst_a_busy", 32'(a_busy), 32'h0);
      chk("rst_b_busy", b_busy, 32'h0);

      // Write then overwrite r1
      a_raddr[0] = 5'd1; b_raddr[0] = 5'd1;
      a_wen = 2'b01; a_waddr[0] = 5'd1; a_wdata[0] = 32'hAAAAAAAA;
      b_wen = 1'b1;  b_waddr[0] = 5'd1; b_wdata[0] = 32'hAAAAAAAA;
      settle();
      chk("byp_same_cycle_w1", a_rdata[0], 32'hAAAAAAAA);
      chk("nobyp_same_cycle_w1", b_rdata[0], 32'h0);
      tick();
      a_wdata[0] = 32'hAAAAAAAF; b_wdata[0] = 32'hAAAAAAAF;
      settle();
      chk("byp_same_cycle_w2", a_rdata[0], 32'hAAAAAAAF);
      chk("nobyp_old_value", b_rdata[0], 32'hAAAAAAAA);
      tick();
      a_wen = '0; b_wen = '0;
      a_wdata[0] = 32'h12345678; b_wdata[0] = 32'h12345678;
      settle();
      chk("nobyp_next_cycle", b_rdata[0], 32'hAAAAAAAF);
      chk("byp_after_write", a_rdata[0], 32'hAAAAAAAF);
      tick();
      chk("a_wen0_hold", a_rdata[0], 32'hAAAAAAAF);
      chk("b_wen0_hold", b_rdata[0], 32'hAAAAAAAF);

      // Zero register ignores writes and claims
      a_raddr[0] = 5'd0; b_raddr[0] = 5'd0;
      a_wen = 2'b01; a_waddr[0] = 5'd0; a_wdata[0] = 32'hFACEAAAA;
      b_wen = 1'b1;  b_waddr[0] = 5'd0; b_wdata[0] = 32'hFACEAAAA;
      a_claim_en = 1'b1; a_claim_idx = 5'd0;
      b_claim_en = 1'b1; b_claim_idx = 5'd0;
      settle();
      chk("a_r0_no_bypass", a_rdata[0], 32'h0);
      tick();
      a_wen = '0; b_wen = '0; a_claim_en = 1'b0; b_claim_en = 1'b0;
      settle();
      chk("a_r0_read", a_rdata[0], 32'h0);
      chk("b_r0_read", b_rdata[0], 32'h0);
      chk("a_r0_busy", 32'(a_busy), 32'h0);
      chk("b_r0_busy", b_busy, 32'h0);
      chk("a_r0_rbusy", 32'(a_rbusy[0]), 32'h0);

      // Dual write to the same index: port 1 wins
      a_raddr[1] = 5'd4;
      a_wen = 2'b11;
      a_waddr[0] = 5'd4; a_wdata[0] = 32'h11111111;
      a_waddr[1] = 5'd4; a_wdata[1] = 32'h22222222;
      settle();
      chk("dual_bypass", a_rdata[1], 32'h22222222);
      tick();
      a_wen = '0;
      settle();
      chk("dual_stored", a_rdata[1], 32'h22222222);

      // Four-port read, including the last register and an out-of-range index
      a_wen = 2'b11;
      a_waddr[0] = 5'd2;  a_wdata[0] = 32'hFACEAAAA;
      a_waddr[1] = 5'd4;  a_wdata[1] = 32'hAAAAFACE;
      tick();
      a_waddr[0] = 5'd8;  a_wdata[0] = 32'hAAFACEAA;
      a_waddr[1] = 5'd16; a_wdata[1] = 32'hFAAAAACE;
      tick();
      a_wen = 2'b01;
      a_waddr[0] = 5'd19; a_wdata[0] = 32'h19191919;
      tick();
      a_wen = 2'b01;
      a_waddr[0] = 5'd25; a_wdata[0] = 32'hDEADBEEF;
      a_raddr = {5'd16, 5'd8, 5'd4, 5'd2};
      settle();
      chk("mr_r2", a_rdata[0], 32'hFACEAAAA);
      chk("mr_r4", a_rdata[1], 32'hAAAAFACE);
      chk("mr_r8", a_rdata[2], 32'hAAFACEAA);
      chk("mr_r16", a_rdata[3], 32'hFAAAAACE);
      tick();
      a_wen = '0;
      a_raddr[0] = 5'd19;
      a_raddr[1] = 5'd25;
      settle();
      chk("mr_r19", a_rdata[0], 32'h19191919);
      chk("mr_oob_r25", a_rdata[1], 32'h0);
      chk("mr_oob_rbusy", 32'(a_rbusy[1]), 32'h0);

      // Scoreboard: claim, clear by write, claim-and-write collision
      a_raddr[0] = 5'd5; b_raddr[0] = 5'd5;
      a_claim_en = 1'b1; a_claim_idx = 5'd5;
      b_claim_en = 1'b1; b_claim_idx = 5'd5;
      settle();
      chk("sb_a_rbusy_pre", 32'(a_rbusy[0]), 32'h0);
      tick();
      a_claim_en = 1'b0; b_claim_en = 1'b0;
      settle();
      chk("sb_a_rbusy_claim", 32'(a_rbusy[0]), 32'h1);
      chk("sb_b_rbusy_claim", 32'(b_rbusy[0]), 32'h1);
      chk("sb_a_busy_vec", 32'(a_busy), 32'h20);
      a_wen = 2'b01; a_waddr[0] = 5'd5; a_wdata[0] = 32'h5;
      b_wen = 1'b1;  b_waddr[0] = 5'd5; b_wdata[0] = 32'h5;
      settle();
      chk("sb_a_rbusy_bypass", 32'(a_rbusy[0]), 32'h0);
      chk("sb_a_rdata_bypass", a_rdata[0], 32'h5);
      chk("sb_b_rbusy_nobyp", 32'(b_rbusy[0]), 32'h1);
      tick();
      a_wen = '0; b_wen = '0;
      settle();
      chk("sb_a_busy_clear", 32'(a_busy), 32'h0);
      chk("sb_b_busy_clear", b_busy, 32'h0);
      chk("sb_b_rdata", b_rdata[0], 32'h5);
      a_wen = 2'b01; a_waddr[0] = 5'd5; a_wdata[0] = 32'h55;
      a_claim_en = 1'b1; a_claim_idx = 5'd5;
      b_wen = 1'b1;  b_waddr[0] = 5'd5; b_wdata[0] = 32'h55;
      b_claim_en = 1'b1; b_claim_idx = 5'd5;
      tick();
      a_wen = '0; b_wen = '0; a_claim_en = 1'b0; b_claim_en = 1'b0;
      settle();
      chk("sb_a_claim_wins", 32'(a_busy), 32'h20);
      chk("sb_b_claim_wins", b_busy, 32'h20);
      chk("sb_a_rbusy_after", 32'(a_rbusy[0]), 32'h1);
      chk("sb_a_rdata_after", a_rdata[0], 32'h55);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the successor to the single-write, two-read `register_file`. It adds configurable width, depth, read-port and write-port counts, same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard for multi-cycle producers. It sits in the decode stage of the core: read ports feed the operand latches, write ports are driven from writeback, and the claim port is driven by issue.

## Interface
- `DATA_W`, 32: register width in bits.
- `DEPTH`, 32: number of registers, range 2..64. Need not be a power of two.
- `NUM_RD`, 2: number of read ports, range 1..4.
- `NUM_WR`, 1: number of write ports, range 1..2.
- `BYPASS`, 1: 1 = same-cycle write data is forwarded to reads.
- `ZERO_REG`, 1: 1 = register 0 always reads 0 and ignores writes and claims.
- `IDX_W`, derived: $clog2(DEPTH).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `wen`  in  NUM_WR  per-port write enable.
- `waddr`  in  NUM_WR x IDX_W  write index per port.
- `wdata`  in  NUM_WR x DATA_W  write data per port.
- `raddr`  in  NUM_RD x IDX_W  read index per port.
- `rdata`  out  NUM_RD x DATA_W  read data per port (combinational).
- `rbusy`  out  NUM_RD  the register at `raddr[i]` has an outstanding producer.
- `claim_en`  in  1  mark one register busy (issue of a multi-cycle op).
- `claim_idx`  in  IDX_W  register to mark busy.
- `busy_vec`  out  DEPTH  registered scoreboard, one bit per register.

## Operation
- Storage: DEPTH x DATA_W flops plus a DEPTH-bit busy vector.
- Write: on each rising edge, `regs[waddr[p]] <= wdata[p]` for every port p with `wen[p]` set.
  - If both ports target the same index, port 1 wins.
  - Writes with index >= DEPTH are dropped.
  - Writes to index 0 are dropped when ZERO_REG=1.
- Read port i (combinational), in priority order:
  1. Index 0 with ZERO_REG=1 → 0.
  2. Index >= DEPTH → 0.
  3. BYPASS=1 and a same-cycle write hits `raddr[i]` → that write's `wdata`, using port-1 priority.
  4. Otherwise → stored value.
- Scoreboard:
  - A write to index k clears `busy[k]`.
  - `claim_en` sets `busy[claim_idx]`.
  - Claim and write to the same index in the same cycle: claim wins and the bit ends set, because the new producer supersedes the old one.
  - Claims with index >= DEPTH are ignored; claims of index 0 are ignored when ZERO_REG=1.
  - A write to a non-busy register is legal and leaves its bit clear.
- `rbusy[i]` = `busy[raddr[i]]`, except it is forced to 0 when BYPASS=1 and a same-cycle write hits `raddr[i]` (the forwarded data is the result).
- Out-of-range or zero-register read indices give `rbusy` = 0.

## Timing
- Reset: while `RST` is high at a rising edge, all registers go to 0 and `busy_vec` goes to 0. Writes and claims in that cycle are ignored.
- Post-reset output values: `rdata` = 0 on every port (or the forwarded value if BYPASS=1 and `wen` is driven), `rbusy` = 0, `busy_vec` = 0.
- Reset may be asserted at any cycle, including mid-claim. Recovery is complete one cycle after deassertion.
- Write latency:
  - BYPASS=0: data is visible on `rdata` the cycle after the write edge.
  - BYPASS=1: data is visible in the same cycle as the write.
- Claim latency: `busy_vec` and `rbusy` reflect a claim from the cycle after `claim_en`.
- No handshakes: every input is sampled every cycle. No backpressure.

## Structure
- Package `regfile_pkg` holds:
  - default-width constants;
  - the `rf_wr_t` struct {en, addr, data};
  - the `idx_valid()` function (range plus zero-register check), shared with the issue logic.
- One sub-module, `rf_scoreboard`, holds the busy vector plus the claim/clear priority logic, and exposes `busy_vec` and a per-read-port lookup.
- Storage, write-port priority and bypass muxing live in `regfile_mp`.

## Test plan
- Reset: preload r1 = 0xAAAAAAAA, then hold `RST` for 2 cycles → all `rdata` = 0, `busy_vec` = 0.
- Write/overwrite and read-after-write, checked with both BYPASS settings:
  - Stimulus: write r1 = 0xAAAAAAAA, then r1 = 0xAAAAAAAF.
  - BYPASS=0: `rdata0` shows the new value the next cycle.
  - BYPASS=1: `rdata0` shows the new value in the same cycle.
  - In both settings, `wen`=0 leaves the value unchanged.
- Zero register (ZERO_REG=1): write r0 = 0xFACEAAAA and claim r0 → `rdata` = 0, `busy_vec[0]` = 0.
- Dual write (NUM_WR=2): same cycle, port 0 writes r4 = 0x11111111 and port 1 writes r4 = 0x22222222 → r4 reads 0x22222222.
- Multiple reads (NUM_RD=4):
  - Stimulus: write r2/r4/r8/r16 = 0xFACEAAAA / 0xAAAAFACE / 0xAAFACEAA / 0xFAAAAACE, then read all four ports at once.
  - Required: all four values returned correctly.
  - With DEPTH=20, reading index 25 returns 0.
- Scoreboard:
  - Claim r5 → `rbusy` is 1 the next cycle.
  - Write r5 = 0x5 → `rbusy` is 0 in the same cycle (BYPASS=1) and the bit is clear the next cycle.
  - Claim and write r5 in the same cycle → `busy[5]` ends at 1.
